muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The parameter shall be XLEN, default 32, giving the operand/result width; only 32 is supported.
REQ-002 Port clk shall be input, width 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n shall be input, width 1: asynchronous, active-low reset.
REQ-004 Port start shall be input, width 1: EX stage holds a valid RV32M instruction.
REQ-005 Port funct3 shall be input, width 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port a shall be input, width XLEN: rs1 operand, already forwarded.
REQ-007 Port b shall be input, width XLEN: rs2 operand, already forwarded.
REQ-008 Port flush shall be input, width 1: the hazard unit's EX flush (FlushE); aborts any operation.
REQ-009 Port busy shall be output, width 1: stall request to the hazard unit (holds F, D, E).
REQ-010 Port done shall be output, width 1: one-cycle pulse; result is valid this cycle.
REQ-011 Port result shall be output, width XLEN: registered result; held until the next accepted start.

Function
REQ-012 The FSM shall have states IDLE, CALC, DONE.
REQ-013 In IDLE with start=1 and flush=0, the unit shall latch funct3, a and b on the edge (the accept edge).
- Special case (divide by zero, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF): go to DONE.
- Otherwise: go to CALC with iteration counter = 0.
REQ-014 Each CALC cycle shall perform one radix-2 step.
- Multiply: shift-add on operand magnitudes, 64-bit product.
- Divide: restoring shift-subtract on magnitudes.
- After exactly 32 CALC cycles: go to DONE.
REQ-015 Latency: for start accepted in cycle T, done shall be 1 in cycle T+33 (normal) or T+1 (special case).
REQ-016 busy shall equal (state==CALC) OR (state==IDLE AND start AND NOT flush), combinationally.
- busy=0 in DONE, so the pipeline advances exactly when done=1.
REQ-017 In DONE, done shall be 1; on the next edge the state shall return to IDLE.
REQ-018 start in DONE or CALC shall be ignored; back-to-back ops are accepted in the following IDLE cycle.
REQ-019 Signedness: MUL/MULH/DIV/REM treat a and b as signed; MULHSU treats a signed, b unsigned; MULHU/DIVU/REMU treat both unsigned.
REQ-020 Result selection:
- MUL: product[31:0].
- MULH*: product[63:32].
- Quotient is negated when operand signs differ (signed ops).
- Remainder takes the sign of the dividend.
REQ-021 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
REQ-022 Signed overflow (0x80000000 / -1): DIV result 0x80000000; REM result 0.
REQ-023 flush=1 in CALC or DONE shall force IDLE on the next edge.
- done stays 0 in that DONE cycle; result is not updated.
REQ-024 flush=1 in IDLE shall block acceptance of start.

Reset
REQ-025 While rst_n=0, immediately and independent of clk:
- state=IDLE, counter=0, done=0, result=0.
- busy=0 regardless of start.
REQ-026 Reset mid-operation shall discard the operation; no done pulse shall follow release.

Verification
REQ-027 MUL a=7, b=0xFFFFFFFD, start in cycle T -> busy=1 cycles T..T+32, done=1 at T+33, result=0xFFFFFFEB.
REQ-028 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> result 0x00000000; both at T+33.
REQ-029 DIVU a=100, b=0 -> done at T+1, result 0xFFFFFFFF; REMU a=100, b=0 -> result 0x00000064.
REQ-030 DIV a=0x80000000, b=0xFFFFFFFF -> done at T+1, result 0x80000000; REM same operands -> 0; REM a=0xFFFFFFF9, b=2 -> result 0xFFFFFFFF at T+33.
REQ-031 DIV a=100, b=7 with flush=1 at CALC cycle 10 -> IDLE next edge, busy=0, no done; new DIV 100/7 then gives result 14 at T'+33.
REQ-032 rst_n low during CALC cycle 5 -> busy=0, done=0, result=0 immediately; no done after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage of an in-order
//   pipeline. Multiply is radix-2 shift-add. Divide is radix-2 restoring
//   shift-subtract. Both work on operand magnitudes and fix the sign at the
//   end. One step is done per CALC cycle. Divide-by-zero and signed overflow
//   skip CALC and finish in a single cycle.
//
// Ports
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : EX holds a valid RV32M instruction
//   funct3  : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM,    111 REMU
//   a, b    : rs1 / rs2 operands (already forwarded)
//   flush   : EX flush from the hazard unit; aborts any operation
//   busy    : stall request (holds F, D, E)
//   done    : one-cycle pulse, result valid this cycle
//   result  : operation result, held until the next completed operation
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;      // negate product / quotient
  logic              neg_r;      // negate remainder (dividend sign)
  logic [XLEN-1:0]   hi;         // product high half / partial remainder
  logic [XLEN-1:0]   lo;         // multiplier bits / dividend-quotient bits
  logic [XLEN-1:0]   mcand;      // multiplicand / divisor magnitude
  logic [XLEN-1:0]   res_calc;   // result of the operation in flight
  logic [XLEN-1:0]   res_q;      // last delivered result

  // ---------------------------------------------------------------------------
  // Accept-edge decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign accept   = (state == IDLE) && start && !flush;
  assign is_div   = funct3[2];
  // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: MUL, MULH, DIV, REM.
  assign a_signed = is_div ? !funct3[0] : (funct3 != 3'b011);
  assign b_signed = is_div ? !funct3[0] : !funct3[1];
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  // Negating INT_MIN wraps back to INT_MIN, which is its correct unsigned magnitude.
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && !funct3[0] && (a == INT_MIN) && (b == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? a : '1;
    else          special_res = funct3[1] ? '0 : INT_MIN;
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand});
  // When div_ge holds, the true difference is below the divisor, so it fits in XLEN bits.
  assign div_sub   = div_shift[XLEN-1:0] - mcand;

  always_comb begin
    step_hi = hi;
    step_lo = lo;
    if (op_q[2]) begin
      step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], div_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, lo[XLEN-1:1]};
    end
  end

  // Sign fix-up and selection, applied to the output of the final step.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fin_res;

  assign prod_s = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

  always_comb begin
    fin_res = '0;
    case (op_q)
      3'b000:                fin_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fin_res = neg_q ? -step_lo : step_lo;
      default:               fin_res = neg_r ? -step_hi : step_hi;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)                  state_next = IDLE;
        else if (cnt == LAST_STEP)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      res_calc <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= '0;
            hi    <= '0;
            lo    <= is_div ? a_mag : b_mag;
            mcand <= is_div ? b_mag : a_mag;
            if (special) res_calc <= special_res;
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) res_calc <= fin_res;
        end
        DONE: begin
          // A flushed completion is discarded; the previous result stays visible.
          if (!flush) res_q <= res_calc;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // rst_n gates busy so that an asserted start cannot stall the pipe during reset.
  assign busy   = rst_n && ((state == CALC) || accept);
  assign done   = (state == DONE) && !flush;
  assign result = done ? res_calc : res_q;

endmodule
